// File: rtl/inst_loader.sv
// inst_loader: receives a program over an 8N1 UART line while in LOAD,
// packs bytes big-endian into 32-bit words, stores them in an internal
// instruction RAM and offers a registered fetch port indexed by pc.
//
// Handshake: the RX path hands bytes to the loader with a one-cycle strobe
// (byte_valid_q) and no back-pressure. rx_shreg_q carries the byte and is
// stable during the strobe cycle. The loader consumes the byte in that
// cycle or drops it (IDLE/DONE, or a coincident load_start).
module inst_loader #(
  parameter int          CLK_PER_BIT = 868,
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_inst,
  output logic              loading,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic [1:0]        dbg_ld_state,
  output logic [2:0]        dbg_rx_state
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} ld_state_t;
  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3
  } rx_state_t;

  // ---------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       rx_shreg_q, rx_shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_set_q, frame_set_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX FSM state register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q   <= R_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      rx_shreg_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_set_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_shreg_q   <= rx_shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_set_q  <= frame_set_d;
    end
  end

  // RX FSM next state: mid-bit sampling, glitch rejection on the start bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    baud_cnt_d   = baud_cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    rx_shreg_d   = rx_shreg_q;
    byte_valid_d = 1'b0;
    frame_set_d  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        baud_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
      end
      R_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          // A line back high at mid start bit was only a glitch.
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          rx_state_d = R_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_set_d  = 1'b1;
        end
      end
      default: begin
        rx_state_d = R_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  ld_state_t         ld_state_q, ld_state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              frame_err_q, frame_err_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       full_word;
  logic [ADDR_W:0]   wc_inc;

  // Loader FSM state register and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state_q   <= IDLE;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      word_count_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      word_count_q <= word_count_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign full_word = {word_buf_q, rx_shreg_q};
  assign wc_inc    = word_count_q + 1'b1;

  // Loader next state: byte packing, terminator detection, RAM write.
  always_comb begin
    ld_state_d   = ld_state_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    word_count_d = word_count_q;
    frame_err_d  = frame_err_q | frame_set_q;
    mem_we       = 1'b0;
    mem_waddr    = word_count_q[IDX_W-1:0];
    mem_wdata    = full_word;
    if (load_start) begin
      // Restart wins over any byte or framing error in the same cycle.
      ld_state_d   = LOAD;
      byte_idx_d   = '0;
      word_buf_d   = '0;
      word_count_d = '0;
      frame_err_d  = 1'b0;
    end else if (ld_state_q == LOAD && byte_valid_q) begin
      if (byte_idx_q != 2'd3) begin
        // Earlier bytes shift toward the MSB, so byte 0 ends up in [31:24].
        word_buf_d = {word_buf_q[15:0], rx_shreg_q};
        byte_idx_d = byte_idx_q + 2'd1;
      end else begin
        byte_idx_d = '0;
        word_buf_d = '0;
        if (full_word == END_WORD) begin
          ld_state_d = DONE;
        end else begin
          mem_we       = 1'b1;
          word_count_d = wc_inc;
          if (wc_inc == DEPTH_W) ld_state_d = DONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Instruction RAM
  // ---------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // Single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered fetch; a same-address write this cycle returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_inst <= '0;
    end else if ({1'b0, fetch_addr} < DEPTH_W) begin
      fetch_inst <= mem[fetch_addr[IDX_W-1:0]];
    end else begin
      fetch_inst <= '0;
    end
  end

  assign loading      = (ld_state_q == LOAD);
  assign load_done    = (ld_state_q == DONE);
  assign word_count   = word_count_q;
  assign frame_err    = frame_err_q;
  assign dbg_ld_state = ld_state_q;
  assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with CLK_PER_BIT=16, DEPTH=4.
module tb_inst_loader;

  localparam int BIT    = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              uart_rx;
  logic              load_start;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_inst;
  logic              loading;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              frame_err;
  logic [1:0]        dbg_ld_state;
  logic [2:0]        dbg_rx_state;

  int n_checks = 0;
  int n_fail   = 0;

  inst_loader #(
    .CLK_PER_BIT(BIT),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .END_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .load_start(load_start),
    .fetch_addr(fetch_addr),
    .fetch_inst(fetch_inst),
    .loading(loading),
    .load_done(load_done),
    .word_count(word_count),
    .frame_err(frame_err),
    .dbg_ld_state(dbg_ld_state),
    .dbg_rx_state(dbg_rx_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    fetch_addr = a;
    @(negedge clk);
    d = fetch_inst;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (fetch_inst !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_inst: got %h expected %h", fetch_inst, 32'h0); end
    n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading: got %b expected 0", loading); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (dbg_ld_state !== 2'd0) begin n_fail++; $display("FAIL reset_ld_state: got %0d expected 0", dbg_ld_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    logic [31:0] d;
    pulse_load_start();
    n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL basic_loading: got %b expected 1", loading); end
    send_word(32'h0002_0820);
    send_word(32'h9234_5676);
    send_word(32'hFFFF_FFFF);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_load_done: got %b expected 1", load_done); end
    n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL basic_loading_off: got %b expected 0", loading); end
    n_checks++; if (word_count !== 9'd2) begin n_fail++; $display("FAIL basic_word_count: got %0d expected 2", word_count); end
    do_fetch(8'd0, d);
    n_checks++; if (d !== 32'h0002_0820) begin n_fail++; $display("FAIL basic_ram0: got %h expected %h", d, 32'h0002_0820); end
    do_fetch(8'd1, d);
    n_checks++; if (d !== 32'h9234_5676) begin n_fail++; $display("FAIL basic_ram1: got %h expected %h", d, 32'h9234_5676); end
    do_fetch(8'd5, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL fetch_out_of_range: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_full();
    logic [31:0] d;
    pulse_load_start();
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL full_done_early: got %b expected 0", load_done); end
    n_checks++; if (word_count !== 9'd3) begin n_fail++; $display("FAIL full_count3: got %0d expected 3", word_count); end
    send_word(32'd4);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", load_done); end
    n_checks++; if (word_count !== 9'd4) begin n_fail++; $display("FAIL full_count4: got %0d expected 4", word_count); end
    do_fetch(8'd3, d);
    n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL full_ram3: got %h expected %h", d, 32'd4); end
    do_fetch(8'd0, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL full_ram0: got %h expected %h", d, 32'd1); end
    send_byte(8'hAB, 1'b1);
    n_checks++; if (word_count !== 9'd4) begin n_fail++; $display("FAIL full_extra_byte_count: got %0d expected 4", word_count); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL full_extra_byte_done: got %b expected 1", load_done); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    pulse_load_start();
    send_byte(8'h55, 1'b0);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL ferr_count0: got %0d expected 0", word_count); end
    send_word(32'hAABB_CCDD);
    n_checks++; if (word_count !== 9'd1) begin n_fail++; $display("FAIL ferr_count1: got %0d expected 1", word_count); end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL ferr_still_loading: got %b expected 1", loading); end
    send_word(32'hFFFF_FFFF);
    do_fetch(8'd0, d);
    n_checks++; if (d !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL ferr_ram0: got %h expected %h", d, 32'hAABB_CCDD); end
    pulse_load_start();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_cleared: got %b expected 0", frame_err); end
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL ferr_restart_count: got %0d expected 0", word_count); end
  endtask

  task automatic test_partial_drop();
    logic [31:0] d;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    pulse_load_start();
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    n_checks++; if (word_count !== 9'd1) begin n_fail++; $display("FAIL partial_count: got %0d expected 1", word_count); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL partial_done: got %b expected 1", load_done); end
    do_fetch(8'd0, d);
    n_checks++; if (d !== 32'h1122_3344) begin n_fail++; $display("FAIL partial_ram0: got %h expected %h", d, 32'h1122_3344); end
  endtask

  task automatic test_reset_mid_byte();
    pulse_load_start();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = i[0];
      repeat (BIT) @(negedge clk);
    end
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (fetch_inst !== 32'h0) begin n_fail++; $display("FAIL midrst_fetch_inst: got %h expected %h", fetch_inst, 32'h0); end
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", word_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_ld_state !== 2'd0) begin n_fail++; $display("FAIL midrst_ld_state: got %0d expected 0", dbg_ld_state); end
    n_checks++; if (dbg_rx_state !== 3'd0) begin n_fail++; $display("FAIL midrst_rx_state: got %0d expected 0", dbg_rx_state); end
    n_checks++; if (loading !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got loading=%b done=%b expected 0 0", loading, load_done); end
    send_word(32'h0102_0304);
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL midrst_ignored_count: got %0d expected 0", word_count); end
    n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL midrst_ignored_loading: got %b expected 0", loading); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    pulse_load_start();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (dbg_rx_state !== 3'd0) begin n_fail++; $display("FAIL glitch_rx_state: got %0d expected 0", dbg_rx_state); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (word_count !== 9'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", word_count); end
    send_word(32'h0102_0304);
    send_word(32'hFFFF_FFFF);
    n_checks++; if (word_count !== 9'd1) begin n_fail++; $display("FAIL glitch_aligned_count: got %0d expected 1", word_count); end
    do_fetch(8'd0, d);
    n_checks++; if (d !== 32'h0102_0304) begin n_fail++; $display("FAIL glitch_ram0: got %h expected %h", d, 32'h0102_0304); end
  endtask

  // Sequencer and final report
  initial begin
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    load_start = 1'b0;
    fetch_addr = '0;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_full();
    test_frame_err();
    test_partial_drop();
    test_reset_mid_byte();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream feeder for the core's instruction memory.
- While the core is in LOAD status, this block receives a program over a UART line (8N1) and packs bytes into 32-bit big-endian words.
- It writes those words into an internal instruction RAM and signals completion.
- In RUN status the core fetches instructions through a registered read port indexed by pc.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 8.
- ADDR_W, 8, instruction RAM address width.
- DEPTH, 256, number of 32-bit words in the RAM; must be <= 2**ADDR_W.
- END_WORD, 32'hFFFF_FFFF, terminator word; it ends loading and is not stored.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- uart_rx  in  1  asynchronous serial input; idle high.
- load_start  in  1  one-cycle pulse; clears counters and enters LOAD.
- fetch_addr  in  ADDR_W  core pc (word address).
- fetch_inst  out  32  instruction at fetch_addr, registered.
- loading  out  1  high while in LOAD.
- load_done  out  1  high in DONE.
- word_count  out  ADDR_W+1  number of words stored in the current load.
- frame_err  out  1  sticky; set on a bad stop bit.

Behaviour:
- Reset is synchronous, active-low. All outputs go to 0: fetch_inst=0, loading=0, load_done=0, word_count=0, frame_err=0.
- Reset puts the loader FSM in IDLE and the RX FSM in R_IDLE. The RAM contents are not reset.
- uart_rx passes through a 2-flop synchronizer before any use.
- RX FSM:
  - R_IDLE: on a synchronized falling edge, go to R_START.
  - R_START: after CLK_PER_BIT/2 cycles, sample the line. If low, go to R_DATA. If high, treat it as a glitch and return to R_IDLE.
  - R_DATA: sample every CLK_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample once after CLK_PER_BIT cycles.
    - If the stop bit is 1, pulse byte_valid for 1 cycle.
    - If it is 0, set frame_err and discard the byte.
    - In both cases return to R_IDLE.
- Loader FSM: IDLE, LOAD, DONE.
  - load_start=1 in any state, in the cycle it is seen: go to LOAD; clear word_count, the byte index, the partial word and frame_err. Any byte_valid in that same cycle is ignored.
  - In IDLE and DONE, byte_valid is ignored.
  - In LOAD, byte k of a word (k=0..3) goes to bits [31-8k:24-8k], so the first byte is the MSB.
  - On the 4th byte, the assembled word W is handled in the same cycle as byte_valid:
    - W==END_WORD: go to DONE. Nothing is written and word_count is unchanged.
    - Otherwise: write RAM[word_count]=W and increment word_count. If the new word_count equals DEPTH, go to DONE.
  - A partial word (1–3 bytes) left when load_start or reset arrives is discarded.
  - loading = (state==LOAD); load_done = (state==DONE), both registered from the state.
- Fetch port:
  - fetch_inst = RAM[fetch_addr], registered, 1-cycle latency, valid in every state.
  - Read-during-write to the same address returns the old data.
  - fetch_addr >= DEPTH returns 0.
- frame_err does not abort the load. It is cleared only by load_start or reset.
- The RAM write port has a single writer: at most one write per cycle.

Test Plan (CLK_PER_BIT=16, DEPTH=4 unless noted):
1. rst_n=0 for 2 cycles, then load_start. Send bytes 00 02 08 20, 92 34 56 76, FF FF FF FF → load_done=1, word_count=2. fetch_addr=0 gives fetch_inst=32'h0002_0820 one cycle later; fetch_addr=1 gives 32'h9234_5676.
2. load_start, then send 16 bytes with no terminator (words 1,2,3,4) → load_done rises right after the 16th byte, word_count=4, RAM[3]=4. A 17th byte is ignored and the counter stays at 4.
3. load_start, then send a byte with stop bit=0, followed by 4 good bytes AA BB CC DD → frame_err=1, RAM[0]=32'hAABB_CCDD, word_count=1. A new load_start clears frame_err.
4. Send 2 bytes, then pulse load_start, then send 11 22 33 44 and a terminator → RAM[0]=32'h1122_3344, word_count=1, so the earlier partial bytes were dropped.
5. Pull rst_n low in the middle of the 3rd byte of a word, then release → all outputs 0, state IDLE. Later bytes are ignored until load_start.
6. A uart_rx low pulse of 4 cycles (shorter than half a bit) → no byte_valid, frame_err=0, word_count unchanged.
